// File: rtl/uart_tx_stage.sv
// 8N1 UART transmitter; byte buffer (holding register, or FIFO when UART_TX_FIFO_EN is defined) feeding a shifter.
// Latency: byte accepted at edge N is popped at N+1, start bit on uart_tx after N+2; frame is 10 bit periods.
// Backpressure: tx_ready = buffer not full, from registered state only; a push into a full buffer waits.
module uart_tx_stage #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic       sysclk,
    input  logic       cpu_resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       tx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2 || FIFO_AW < 1) begin : g_bad_cfg
        $error("uart_tx_stage: CLK_FREQ/BAUD must be >= 2 and FIFO_AW >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             line;
    logic             bit_end;
    logic             pop;
    logic             push;
    logic             buf_empty;
    logic [7:0]       buf_head;

    assign push = tx_valid && tx_ready;

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic             full;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign buf_empty = (wr_ptr == rd_ptr);
    assign buf_head  = mem[rd_ptr[FIFO_AW-1:0]];
    assign tx_ready  = !full;

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= tx_data;
    end
`else
    logic       hold_vld;
    logic [7:0] hold_dat;

    assign buf_empty = !hold_vld;
    assign buf_head  = hold_dat;
    assign tx_ready  = !hold_vld;

    // push needs an empty register and pop a full one, so they never coincide.
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            hold_vld <= 1'b0;
            hold_dat <= '0;
        end else if (push) begin
            hold_vld <= 1'b1;
            hold_dat <= tx_data;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end
`endif

    assign bit_end = (cnt == CNT_LAST);
    assign tx_busy = (state != S_IDLE) || !buf_empty;

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            uart_tx <= line;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        pop       = 1'b0;
        line      = 1'b1;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (!buf_empty) begin
                    pop       = 1'b1;
                    shift_nxt = buf_head;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                line    = 1'b0;
                cnt_nxt = cnt + 1'b1;
                if (bit_end) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                line    = shift[0];
                cnt_nxt = cnt + 1'b1;
                if (bit_end) begin
                    cnt_nxt   = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_nxt   = '0;
                        state_nxt = S_STOP;
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                    end
                end
            end
            S_STOP: begin
                cnt_nxt = cnt + 1'b1;
                if (bit_end) begin
                    cnt_nxt = '0;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (!buf_empty) begin
                        pop       = 1'b1;
                        shift_nxt = buf_head;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_stage.sv
// Directed-plus-random bench for uart_tx_stage: a line decoder feeds rx_q, compared with the accepted-byte scoreboard.
module tb_uart_tx_stage;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = 10;
    localparam int FRAME    = 10 * CPB;
    localparam int T        = 10;
`ifdef UART_TX_FIFO_EN
    localparam int CAP       = 16;
    localparam int FILL_SPAN = 16;
`else
    localparam int CAP       = 1;
    localparam int FILL_SPAN = 2;
`endif

    logic       sysclk = 1'b0;
    logic       cpu_resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_tx;
    logic       tx_busy;

    uart_tx_stage #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_AW(4)) dut (
        .sysclk    (sysclk),
        .cpu_resetn(cpu_resetn),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy)
    );

    always #(T/2) sysclk = ~sysclk;

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         rst_cnt = 0;
    int         frame_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    time        start_q[$];

    always @(posedge sysclk) cyc <= cyc + 1;
    always @(negedge cpu_resetn) rst_cnt++;

    // Line decoder: samples mid-bit; frames cut by a reset are discarded.
    always begin : mon
        int         r0;
        logic [7:0] b;
        logic       ok;
        @(negedge uart_tx);
        r0 = rst_cnt;
        ok = 1'b1;
        start_q.push_back($time);
        repeat (CPB/2) @(posedge sysclk);
        #1;
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge sysclk);
            #1;
            b[i] = uart_tx;
        end
        repeat (CPB) @(posedge sysclk);
        #1;
        if (uart_tx !== 1'b1) ok = 1'b0;
        if (rst_cnt == r0) begin
            if (ok) rx_q.push_back(b);
            else    frame_err++;
        end
    end

    initial begin
        #(T * 60000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic push(input logic [7:0] b, input int limit, output bit ok, output int c);
        logic rdy;
        ok = 1'b0;
        c = 0;
        tx_data = b;
        tx_valid = 1'b1;
        for (int i = 0; i < limit; i++) begin
            rdy = tx_ready;
            @(posedge sysclk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                c = cyc;
                exp_q.push_back(b);
                break;
            end
        end
        tx_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((tx_busy || rx_q.size() < exp_q.size()) && guard < 3000) begin
            @(posedge sysclk);
            #1;
            guard++;
        end
        repeat (10) @(posedge sysclk);
        #1;
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_byte"}, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
        check({tag, "_framing"}, frame_err, 0);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit         ok;
        int         c0, c, n_acc, errs, gap;
        logic       busy_hi, busy_lo, lvl;
        logic [7:0] b;

        cpu_resetn = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        repeat (5) @(posedge sysclk);
        #1;
        check("rst_line", uart_tx, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        cpu_resetn = 1'b1;
        repeat (50) @(posedge sysclk);
        #1;
        check("idle_line", uart_tx, 1);
        check("idle_ready", tx_ready, 1);
        check("idle_busy", tx_busy, 0);
        check("idle_no_frame", start_q.size(), 0);

        // Single byte: exact waveform from the 8N1 rule, start bit two edges after accept.
        b = 8'hA5;
        push(b, 10, ok, c0);
        check("a5_accept", ok, 1);
        check("a5_line_edge_n", uart_tx, 1);
        @(posedge sysclk);
        #1;
        check("a5_line_edge_n1", uart_tx, 1);
        check("a5_busy_edge_n1", tx_busy, 1);
        errs = 0;
        busy_hi = 1'b0;
        busy_lo = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            @(posedge sysclk);
            #1;
            if (k < CPB)             lvl = 1'b0;
            else if (k >= 9 * CPB)   lvl = 1'b1;
            else                     lvl = b[k / CPB - 1];
            if (uart_tx !== lvl) errs++;
            if (k == FRAME - 2) busy_hi = tx_busy;
            if (k == FRAME - 1) busy_lo = tx_busy;
        end
        check("a5_wave_errs", errs, 0);
        check("a5_busy_before_end", busy_hi, 1);
        check("a5_busy_falls", busy_lo, 0);
        drain("a5");

        // Back-to-back frames with no idle gap.
        start_q.delete();
        push(8'h55, 10, ok, c0);
        check("b2b_accept0", ok, 1);
        push(8'h0F, 20, ok, c);
        check("b2b_accept1", ok, 1);
        drain("b2b");
        gap = (start_q.size() >= 2) ? int'(start_q[1] - start_q[0]) : 0;
        check("b2b_gap", gap, FRAME * T);

        // Backpressure: fill the buffer, then the next byte waits for the first frame to finish.
        n_acc = 0;
        push(8'($urandom), 10, ok, c0);
        n_acc += int'(ok);
        c = c0;
        for (int i = 0; i < CAP; i++) begin
            push(8'($urandom), 10, ok, c);
            n_acc += int'(ok);
        end
        check("bp_fill_span", c - c0, FILL_SPAN);
        check("bp_full_ready", tx_ready, 0);
        push(8'($urandom), 300, ok, c);
        n_acc += int'(ok);
        check("bp_accepts", n_acc, CAP + 2);
        check("bp_release_cycle", c - c0, FRAME + 2);
        drain("bp");

        // tx_valid with changing data while not ready must not add bytes.
        for (int i = 0; i <= CAP; i++) push(8'($urandom), 10, ok, c);
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            tx_valid = 1'b1;
            tx_data = 8'($urandom);
            if (tx_ready !== 1'b0) errs++;
            @(posedge sysclk);
            #1;
        end
        tx_valid = 1'b0;
        check("ign_ready_low", errs, 0);
        drain("ign");

        // Reset in the middle of bit 4, with a second byte buffered.
        push(8'h3C, 10, ok, c0);
        push(8'h99, 20, ok, c);
        check("mid_accept", ok, 1);
        while (cyc < c0 + 57) begin
            @(posedge sysclk);
            #1;
        end
        check("mid_busy_pre", tx_busy, 1);
        check("mid_line_bit4", uart_tx, 1);
        cpu_resetn = 1'b0;
        #1;
        check("mid_rst_line", uart_tx, 1);
        check("mid_rst_ready", tx_ready, 1);
        check("mid_rst_busy", tx_busy, 0);
        exp_q.delete();
        repeat (3) @(posedge sysclk);
        #1;
        cpu_resetn = 1'b1;
        repeat (120) @(posedge sysclk);
        #1;
        check("mid_no_rx", rx_q.size(), 0);
        check("mid_busy_post", tx_busy, 0);
        check("mid_line_post", uart_tx, 1);
        push(8'h81, 10, ok, c);
        check("post_accept", ok, 1);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
